// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the
// parametrised convolution controller.
package conv_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_LOADC = 4'b0010,
    S_RUN   = 4'b0100,
    S_DRAIN = 4'b1000
  } conv_state_t;

  // Coefficients per kernel
  function automatic int kk_of(input int k);
    return k * k;
  endfunction

  // Committed-bank width in bits
  function automatic int fw_of(input int k, input int cw);
    return k * k * cw;
  endfunction

  // Counter width for a range of n values
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_valid_delay.sv
// LAT-deep delay line carrying the window-valid
// bit from pixel acceptance to MAC result.
module conv_valid_delay #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] sr;

  generate
    if (LAT == 1) begin : g_one
      // Single-stage register
      always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= din;
      end
    end else begin : g_many
      // Shift toward the MSB each cycle
      always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[LAT-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[LAT-1];

endmodule

// File: rtl/conv_ctrl_param.sv
// Convolution filter controller: kernel load via
// shadow bank, frame scan, write strobe and MAC enable.
module conv_ctrl_param
  import conv_pkg::*;
#(
  parameter int N   = 32,
  parameter int M   = 32,
  parameter int K   = 3,
  parameter int CW  = 8,
  parameter int LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_load,
  input  logic              coeff_load,
  input  logic [CW-1:0]     coeff_in,
  output logic              data_write,
  output logic [K*K*CW-1:0] filter,
  output logic              enable,
  output logic              coeff_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int KK  = kk_of(K);
  localparam int FW  = fw_of(K, CW);
  localparam int SW  = FW - CW;
  localparam int BW  = cnt_w(KK);
  localparam int CLW = cnt_w(N);
  localparam int RW  = cnt_w(M);
  localparam int DW  = cnt_w(LAT + 1);

  localparam logic [BW-1:0]  BEAT_LAST  = BW'(KK - 1);
  localparam logic [CLW-1:0] COL_LAST   = CLW'(N - 1);
  localparam logic [RW-1:0]  ROW_LAST   = RW'(M - 1);
  localparam logic [CLW-1:0] COL_WIN    = CLW'(K - 1);
  localparam logic [RW-1:0]  ROW_WIN    = RW'(K - 1);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(LAT);

  conv_state_t    state, state_nxt;
  logic [SW-1:0]  shadow;
  logic [FW-1:0]  bank;
  logic           cv;
  logic [BW-1:0]  beat;
  logic [CLW-1:0] col;
  logic [RW-1:0]  row;
  logic [DW-1:0]  dcnt;
  logic           accept;
  logic           shift_en;
  logic           commit;
  logic           done;
  logic           last_px;
  logic           win;

  assign last_px = (row == ROW_LAST) && (col == COL_LAST);
  assign win     = accept && (row >= ROW_WIN) && (col >= COL_WIN);

  // Next state and per-cycle strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (coeff_load) begin
          shift_en  = 1'b1;
          state_nxt = S_LOADC;
        end else if (data_load && cv) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_LOADC: begin
        if (coeff_load) begin
          shift_en = 1'b1;
          if (beat == BEAT_LAST) begin
            commit    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_RUN: begin
        if (data_load) begin
          accept = 1'b1;
          if (last_px) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dcnt == DRAIN_LAST) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Shadow shift and commit into the live bank
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      bank   <= '0;
      cv     <= 1'b0;
      beat   <= '0;
    end else if (shift_en) begin
      shadow <= {shadow[SW-CW-1:0], coeff_in};
      beat   <= commit ? '0 : beat + BW'(1);
      if (commit) begin
        bank <= {shadow, coeff_in};
        cv   <= 1'b1;
      end
    end
  end

  // Raster position; wraps to (0,0) after the last pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CLW'(1);
      end
    end
  end

  // Drain timer counting out the datapath latency
  always_ff @(posedge clk) begin
    if (rst)
      dcnt <= '0;
    else if (state == S_DRAIN && !done)
      dcnt <= dcnt + DW'(1);
    else
      dcnt <= '0;
  end

  conv_valid_delay #(
    .LAT (LAT)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (win),
    .dout (enable)
  );

  assign data_write  = accept;
  assign filter      = cv ? bank : '0;
  assign coeff_valid = cv;
  assign busy        = (state != S_IDLE);
  assign frame_done  = done;

endmodule

// File: tb/tb_conv_ctrl_param.sv
// Scoreboard bench for conv_ctrl_param on an
// 8x8 frame with a 3x3 kernel.
module tb_conv_ctrl_param;

  localparam int N   = 8;
  localparam int M   = 8;
  localparam int K   = 3;
  localparam int CW  = 8;
  localparam int LAT = 2;
  localparam int FW  = K * K * CW;
  localparam int NWIN = (M - K + 1) * (N - K + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_load = 1'b0;
  logic          coeff_load = 1'b0;
  logic [CW-1:0] coeff_in = '0;
  logic          data_write;
  logic [FW-1:0] filter;
  logic          enable;
  logic          coeff_valid;
  logic          busy;
  logic          frame_done;

  conv_ctrl_param #(
    .N   (N),
    .M   (M),
    .K   (K),
    .CW  (CW),
    .LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_load   (data_load),
    .coeff_load  (coeff_load),
    .coeff_in    (coeff_in),
    .data_write  (data_write),
    .filter      (filter),
    .enable      (enable),
    .coeff_valid (coeff_valid),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_q[$];
  logic          m_run;
  logic          m_cv;
  logic [FW-1:0] m_filter;
  int m_row, m_col, last_cyc;
  int n_wr, n_en, n_fd, n_acc;

  task automatic model_reset();
    m_run    = 1'b0;
    m_cv     = 1'b0;
    m_filter = '0;
    m_row    = 0;
    m_col    = 0;
    last_cyc = -100;
    exp_q.delete();
  endtask

  // One clock cycle: drive, then check every output
  task automatic tick(input logic dl, input logic cl,
                      input logic [CW-1:0] ci);
    logic exp_wr, exp_en, exp_fd;
    @(negedge clk);
    data_load  = dl;
    coeff_load = cl;
    coeff_in   = ci;
    #1;
    cyc++;
    exp_wr = m_run && dl;
    tests++;
    if (data_write !== exp_wr) begin
      fails++;
      $display("FAIL data_write cyc=%0d got=%b exp=%b",
               cyc, data_write, exp_wr);
    end
    if (exp_wr) begin
      n_wr++;
      n_acc++;
      if (m_row >= K - 1 && m_col >= K - 1)
        exp_q.push_back(cyc + LAT);
      if (m_col == N - 1) begin
        m_col = 0;
        if (m_row == M - 1) begin
          m_row    = 0;
          m_run    = 1'b0;
          last_cyc = cyc;
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
    end
    exp_en = (exp_q.size() > 0) && (exp_q[0] == cyc);
    tests++;
    if (enable !== exp_en) begin
      fails++;
      $display("FAIL enable cyc=%0d got=%b exp=%b",
               cyc, enable, exp_en);
    end
    if (exp_en) void'(exp_q.pop_front());
    if (enable === 1'b1) n_en++;
    exp_fd = (cyc == last_cyc + LAT + 1);
    tests++;
    if (frame_done !== exp_fd) begin
      fails++;
      $display("FAIL frame_done cyc=%0d got=%b exp=%b",
               cyc, frame_done, exp_fd);
    end
    if (frame_done === 1'b1) n_fd++;
    if (exp_fd) begin
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_drain cyc=%0d got=%b exp=1",
                 cyc, busy);
      end
    end
    tests++;
    if (filter !== m_filter) begin
      fails++;
      $display("FAIL filter cyc=%0d got=%h exp=%h",
               cyc, filter, m_filter);
    end
    tests++;
    if (coeff_valid !== m_cv) begin
      fails++;
      $display("FAIL coeff_valid cyc=%0d got=%b exp=%b",
               cyc, coeff_valid, m_cv);
    end
  endtask

  task automatic check_idle_zero(input string nm);
    tests++;
    if ({data_write, enable, frame_done, busy, coeff_valid} !== 5'b0
        || filter !== '0) begin
      fails++;
      $display("FAIL %s got wr=%b en=%b fd=%b bsy=%b cv=%b flt=%h exp=all 0",
               nm, data_write, enable, frame_done, busy,
               coeff_valid, filter);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    data_load  = 1'b0;
    coeff_load = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("reset_outputs");
    rst = 1'b0;
    model_reset();
    tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
  endtask

  task automatic test_load(input logic [CW-1:0] base,
                           input logic [CW-1:0] step,
                           input bit stalls);
    logic [FW-1:0] acc;
    logic [CW-1:0] v;
    acc = '0;
    for (int i = 0; i < K * K; i++) begin
      if (stalls && (i == 3 || i == 6))
        tick(1'b1, 1'b0, 8'hAA);
      v = CW'(int'(base) + int'(step) * i);
      tick(i == 0, 1'b1, v);
      acc = {acc[FW-CW-1:0], v};
      if (i == 1) begin
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL busy_loadc got=%b exp=1", busy);
        end
      end
    end
    m_filter = acc;
    m_cv     = 1'b1;
    tick(1'b0, 1'b0, '0);
    tests++;
    if (filter !== acc) begin
      fails++;
      $display("FAIL filter_commit got=%h exp=%h", filter, acc);
    end
  endtask

  task automatic test_frame(input int pct_low, input int coeff_at,
                            input int stop_at, input string nm);
    int   guard;
    bit   pulsed;
    logic dl, cl;
    n_wr   = 0;
    n_en   = 0;
    n_fd   = 0;
    n_acc  = 0;
    guard  = 0;
    pulsed = 0;
    m_run  = 1'b1;
    while (m_run && guard < 2000) begin
      dl = ($urandom_range(0, 99) >= pct_low);
      cl = (coeff_at >= 0) && (n_acc == coeff_at) && !pulsed;
      if (cl) pulsed = 1;
      tick(dl, cl, 8'h55);
      guard++;
      if (stop_at > 0 && n_acc == stop_at) return;
    end
    tests++;
    if (m_run) begin
      fails++;
      $display("FAIL %s_timeout accepted=%0d exp=%0d",
               nm, n_acc, N * M);
      m_run = 1'b0;
    end
    repeat (LAT + 1) tick(1'b1, 1'b0, '0);
    tests++;
    if (n_wr != N * M) begin
      fails++;
      $display("FAIL %s_writes got=%0d exp=%0d", nm, n_wr, N * M);
    end
    tests++;
    if (n_en != NWIN) begin
      fails++;
      $display("FAIL %s_enables got=%0d exp=%0d", nm, n_en, NWIN);
    end
    tests++;
    if (n_fd != 1) begin
      fails++;
      $display("FAIL %s_done_pulses got=%0d exp=1", nm, n_fd);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_pending got=%0d exp=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_midreset();
    @(negedge clk);
    rst        = 1'b1;
    data_load  = 1'b1;
    coeff_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_zero("midreset_outputs");
    model_reset();
    n_wr = 0;
    repeat (5) tick(1'b1, 1'b0, '0);
    tests++;
    if (n_wr != 0) begin
      fails++;
      $display("FAIL midreset_ignored got=%0d exp=0", n_wr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_load(8'h01, 8'h01, 1'b1);
    test_frame(0, -1, 0, "frame_contig");
    test_frame(50, -1, 0, "frame_random");
    test_frame(0, 20, 0, "frame_coeffpulse");
    test_load(8'hFF, 8'h00, 1'b0);
    test_frame(0, -1, 30, "frame_partial");
    test_midreset();
    test_load(8'h01, 8'h01, 1'b0);
    test_frame(0, -1, 0, "frame_recover");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
